// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 data mux.
// Optional hold-timeout preemption is compiled in with `define ARB_TIMEOUT_EN.
module mux2_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             done,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             sel,
  output logic             busy,
  output logic             preempt,
  output logic [WIDTH-1:0] mux_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_sel;
  logic   r_last;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_preempt;
  logic             w_preempt_nxt;
`endif

  // State register plus select and last-served pointer, all tracking the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == OWN0) begin
        r_sel <= 1'b0;
      end else if (w_state_nxt == OWN1) begin
        r_sel <= 1'b1;
      end
      if ((w_state_nxt == OWN0) && (r_state != OWN0)) begin
        r_last <= 1'b0;
      end else if ((w_state_nxt == OWN1) && (r_state != OWN1)) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next-state decode; release (abort or done) outranks timeout, which outranks holding.
  always_comb begin
    w_state_nxt = r_state;
`ifdef ARB_TIMEOUT_EN
    w_preempt_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (req_0 && req_1) begin
          w_state_nxt = r_last ? OWN0 : OWN1;
        end else if (req_0) begin
          w_state_nxt = OWN0;
        end else if (req_1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!req_0 || done) begin
          if (req_1) begin
            w_state_nxt = OWN1;
          end else if (req_0 && done) begin
            w_state_nxt = OWN0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if ((r_cnt == LP_HOLD_MAX) && req_1) begin
          w_state_nxt   = OWN1;
          w_preempt_nxt = 1'b1;
        end
`endif
      end
      OWN1: begin
        if (!req_1 || done) begin
          if (req_0) begin
            w_state_nxt = OWN0;
          end else if (req_1 && done) begin
            w_state_nxt = OWN1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if ((r_cnt == LP_HOLD_MAX) && req_0) begin
          w_state_nxt   = OWN0;
          w_preempt_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter restarts on any ownership change, on done-restart and in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_preempt_nxt;
      if ((w_state_nxt != r_state) || (w_state_nxt == IDLE) || done) begin
        r_cnt <= '0;
      end else if (r_cnt != LP_HOLD_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign preempt = r_preempt;
`else
  logic [CNT_W-1:0] w_unused_hold;
  assign w_unused_hold = CNT_W'(MAX_HOLD - 1);
  assign preempt       = 1'b0;
`endif

  assign gnt_0   = (r_state == OWN0);
  assign gnt_1   = (r_state == OWN1);
  assign busy    = gnt_0 | gnt_1;
  assign sel     = r_sel;
  assign mux_out = r_sel ? din_1 : din_0;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter; expectations follow ARB_TIMEOUT_EN if defined.
module tb_mux2_arbiter;

  logic        clk;
  logic        reset;
  logic        req_0;
  logic        req_1;
  logic        done;
  logic [31:0] din_0;
  logic [31:0] din_1;
  logic        gnt_0;
  logic        gnt_1;
  logic        sel;
  logic        busy;
  logic        preempt;
  logic [31:0] mux_out;

  int errors;
  int checks;

  mux2_arbiter #(.WIDTH(32), .MAX_HOLD(8), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_0   (req_0),
    .req_1   (req_1),
    .done    (done),
    .din_0   (din_0),
    .din_1   (din_1),
    .gnt_0   (gnt_0),
    .gnt_1   (gnt_1),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt),
    .mux_out (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_0 = 1'b1; req_1 = 1'b1; done = 1'b0;
    tick();
    tick();
    checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL rst_gnt_0: got %b want 0", gnt_0); end
    checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL rst_gnt_1: got %b want 0", gnt_1); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b want 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL rst_preempt: got %b want 0", preempt); end
    reset = 1'b0;
    tick();
    checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL rst_first_gnt_0: got %b want 1", gnt_0); end
    checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL rst_first_gnt_1: got %b want 0", gnt_1); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rst_first_sel: got %b want 0", sel); end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_to_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_single_req1();
    din_0 = 32'h0; din_1 = 32'hDEADBEEF; req_1 = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b1) begin errors++; $display("FAIL req1_gnt_1: got %b want 1", gnt_1); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL req1_sel: got %b want 1", sel); end
    checks++; if (mux_out !== 32'hDEADBEEF) begin errors++; $display("FAIL req1_mux_out: got %h want deadbeef", mux_out); end
    tick();
    tick();
    checks++; if (gnt_1 !== 1'b1) begin errors++; $display("FAIL req1_hold: got %b want 1", gnt_1); end
    done = 1'b1; req_1 = 1'b0;
    tick();
    done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req1_release_busy: got %b want 0", busy); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL req1_idle_sel_hold: got %b want 1", sel); end
    checks++; if (mux_out !== 32'hDEADBEEF) begin errors++; $display("FAIL req1_idle_mux: got %h want deadbeef", mux_out); end
  endtask

  task automatic test_done_idle();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    din_0 = 32'h12345678; req_0 = 1'b1;
    tick();
    checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL abort_own0: got %b want 1", gnt_0); end
    checks++; if (mux_out !== 32'h12345678) begin errors++; $display("FAIL abort_mux0: got %h want 12345678", mux_out); end
    req_0 = 1'b0; req_1 = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b1) begin errors++; $display("FAIL abort_gnt_1: got %b want 1", gnt_1); end
    checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL abort_gnt_0: got %b want 0", gnt_0); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL abort_sel: got %b want 1", sel); end
    req_1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
  endtask

  task automatic test_restart();
    req_0 = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL restart_gnt_0: got %b want 1", gnt_0); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL restart_preempt: got %b want 0", preempt); end
    req_0 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle: got %b want 0", busy); end
  endtask

  // Last served is requester 0 here, so the tie goes to requester 1 first.
  task automatic test_back_to_back();
    logic own;
    req_0 = 1'b1; req_1 = 1'b1; done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      own = ((k % 2) == 0);
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++; if (gnt_0 !== !own || gnt_1 !== own) begin errors++; $display("FAIL b2b_owner k=%0d c=%0d: got gnt_0=%b gnt_1=%b want owner %b", k, c, gnt_0, gnt_1, own); end
        checks++; if ((gnt_0 & gnt_1) !== 1'b0) begin errors++; $display("FAIL b2b_exclusive k=%0d c=%0d: got %b want 0", k, c, gnt_0 & gnt_1); end
        checks++; if (sel !== own) begin errors++; $display("FAIL b2b_sel k=%0d c=%0d: got %b want %b", k, c, sel, own); end
        done = (c == 2);
      end
    end
    req_0 = 1'b0; req_1 = 1'b0; done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    din_0 = 32'hA5A5A5A5; din_1 = 32'h5A5A5A5A; req_0 = 1'b1;
    tick();
    req_1 = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      checks++; if (gnt_0 !== 1'b1 || preempt !== 1'b0) begin errors++; $display("FAIL to_hold cyc=%0d: got gnt_0=%b preempt=%b want 1,0", i, gnt_0, preempt); end
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL to_handoff: got gnt_0=%b gnt_1=%b want 0,1", gnt_0, gnt_1); end
    checks++; if (preempt !== 1'b1) begin errors++; $display("FAIL to_preempt: got %b want 1", preempt); end
    checks++; if (mux_out !== 32'h5A5A5A5A) begin errors++; $display("FAIL to_mux: got %h want 5a5a5a5a", mux_out); end
    tick();
    checks++; if (gnt_1 !== 1'b1 || preempt !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got gnt_1=%b preempt=%b want 1,0", gnt_1, preempt); end
`else
    for (int i = 9; i <= 12; i++) begin
      checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0 || preempt !== 1'b0) begin errors++; $display("FAIL noto_hold cyc=%0d: got gnt_0=%b gnt_1=%b preempt=%b want 1,0,0", i, gnt_0, gnt_1, preempt); end
      tick();
    end
    checks++; if (mux_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL noto_mux: got %h want a5a5a5a5", mux_out); end
`endif
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req_1 = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL rmid_own1: got gnt_1=%b sel=%b want 1,1", gnt_1, sel); end
    reset = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL rmid_gnt_1: got %b want 0", gnt_1); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rmid_sel: got %b want 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    req_0 = 1'b1; reset = 1'b0;
    tick();
    checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL rmid_tie: got gnt_0=%b gnt_1=%b want 1,0", gnt_0, gnt_1); end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", busy); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; done = 1'b0;
    din_0 = 32'h0; din_1 = 32'h0;
    test_reset();
    test_single_req1();
    test_done_idle();
    test_abort();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
